// File: rtl/dmi_arbiter_if.sv
// DMI bus bundle between two debug transport masters, the arbiter and the debug module.
// The slave modport is the arbiter's view; the master modport is the harness driving it.
interface dmi_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  // Master-facing side (two sources, packed per index)
  logic [1:0]              m_req_valid_i;
  logic [1:0]              m_req_ready_o;
  logic [2*ADDR_WIDTH-1:0] m_req_addr_i;
  logic [3:0]              m_req_op_i;
  logic [2*DATA_WIDTH-1:0] m_req_data_i;
  logic [1:0]              m_resp_valid_o;
  logic [1:0]              m_resp_ready_i;
  logic [1:0]              m_resp_resp_o;
  logic [DATA_WIDTH-1:0]   m_resp_data_o;
  // Debug-module-facing side
  logic                    s_req_valid_o;
  logic                    s_req_ready_i;
  logic [ADDR_WIDTH-1:0]   s_req_addr_o;
  logic [1:0]              s_req_op_o;
  logic [DATA_WIDTH-1:0]   s_req_data_o;
  logic                    s_resp_valid_i;
  logic                    s_resp_ready_o;
  logic [1:0]              s_resp_resp_i;
  logic [DATA_WIDTH-1:0]   s_resp_data_i;

  modport slave (
    input  m_req_valid_i, m_req_addr_i, m_req_op_i, m_req_data_i, m_resp_ready_i,
    output m_req_ready_o, m_resp_valid_o, m_resp_resp_o, m_resp_data_o,
    output s_req_valid_o, s_req_addr_o, s_req_op_o, s_req_data_o, s_resp_ready_o,
    input  s_req_ready_i, s_resp_valid_i, s_resp_resp_i, s_resp_data_i
  );

  modport master (
    output m_req_valid_i, m_req_addr_i, m_req_op_i, m_req_data_i, m_resp_ready_i,
    input  m_req_ready_o, m_resp_valid_o, m_resp_resp_o, m_resp_data_o,
    input  s_req_valid_o, s_req_addr_o, s_req_op_o, s_req_data_o, s_resp_ready_o,
    output s_req_ready_i, s_resp_valid_i, s_resp_resp_i, s_resp_data_i
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter for two DMI masters onto one debug module port, single outstanding
// transaction, response routed to the issuing master, timeout turns a hung DM into an error.
module dmi_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  en_i,
  dmi_arbiter_if.slave bus,
  output logic        stray_o,
  output logic        owner_o,
  output logic [1:0]  state_o,
  output logic        rr_ptr_o
);
  // Every channel transfers on the rising edge where valid and ready are both 1;
  // valid never waits on ready, and payload is held stable while valid is high.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rr;
  logic                  r_owner;
  logic                  r_stray;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data;

  logic [1:0]            w_elig;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_done;
  logic [1:0]            w_req_ready;
  logic [1:0]            w_resp_valid;
  logic [1:0]            w_resp_resp;
  logic [DATA_WIDTH-1:0] w_resp_data;
  logic                  w_s_req_valid;
  logic                  w_s_resp_ready;

  assign w_elig = bus.m_req_valid_i & en_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant        = 1'b0;
    w_accept       = 1'b0;
    w_done         = 1'b0;
    w_req_ready    = 2'b00;
    w_resp_valid   = 2'b00;
    w_resp_resp    = 2'b00;
    w_resp_data    = '0;
    w_s_req_valid  = 1'b0;
    w_s_resp_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Responses arriving here have no owner; swallow them and flag stray.
        w_s_resp_ready = 1'b1;
        if (|w_elig) begin
          w_grant              = w_elig[r_rr] ? r_rr : ~r_rr;
          w_req_ready[w_grant] = 1'b1;
          w_accept             = 1'b1;
          w_state_nxt          = S_REQ;
        end
      end
      S_REQ: begin
        w_s_req_valid = 1'b1;
        if (bus.s_req_ready_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_resp_valid[r_owner] = bus.s_resp_valid_i;
        w_s_resp_ready        = bus.m_resp_ready_i[r_owner];
        w_resp_resp           = bus.s_resp_resp_i;
        w_resp_data           = bus.s_resp_data_i;
        if (bus.s_resp_valid_i && bus.m_resp_ready_i[r_owner]) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        w_resp_valid[r_owner] = 1'b1;
        w_resp_resp           = 2'b10;
        w_s_resp_ready        = 1'b1;
        if (bus.m_resp_ready_i[r_owner]) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_stray <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_op    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_grant;
        r_addr  <= w_grant ? bus.m_req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : bus.m_req_addr_i[ADDR_WIDTH-1:0];
        r_op    <= w_grant ? bus.m_req_op_i[3:2] : bus.m_req_op_i[1:0];
        r_data  <= w_grant ? bus.m_req_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                           : bus.m_req_data_i[DATA_WIDTH-1:0];
      end
      // Counter is zero on entry to RESP and saturates rather than wrapping.
      if (r_state == S_REQ) begin
        r_cnt <= '0;
      end else if (r_state == S_RESP && !w_done && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) r_rr <= ~r_owner;
      if (bus.s_resp_valid_i && (r_state == S_IDLE || r_state == S_REQ)) r_stray <= 1'b1;
    end
  end

  assign bus.m_req_ready_o  = w_req_ready;
  assign bus.m_resp_valid_o = w_resp_valid;
  assign bus.m_resp_resp_o  = w_resp_resp;
  assign bus.m_resp_data_o  = w_resp_data;
  assign bus.s_req_valid_o  = w_s_req_valid;
  assign bus.s_req_addr_o   = r_addr;
  assign bus.s_req_op_o     = r_op;
  assign bus.s_req_data_o   = r_data;
  assign bus.s_resp_ready_o = w_s_resp_ready;

  assign stray_o  = r_stray;
  assign owner_o  = r_owner;
  assign state_o  = r_state;
  assign rr_ptr_o = r_rr;
endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: stimulus pushes expected slave requests and master
// responses into queues; a negedge monitor pops and compares at every handshake.
module tb_dmi_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  logic       stray_o;
  logic       owner_o;
  logic [1:0] state_o;
  logic       rr_ptr_o;

  int n_checks;
  int n_errors;

  logic [41:0] exp_req_q[$];  // {owner, addr, op, data}
  logic [34:0] exp_rsp_q[$];  // {master, resp, data}

  dmi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .bus     (bus),
    .stray_o (stray_o),
    .owner_o (owner_o),
    .state_o (state_o),
    .rr_ptr_o(rr_ptr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m_req_valid_i  = 2'b00;
    bus.s_req_ready_i  = 1'b0;
    bus.s_resp_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic drive_req(input int m, input logic [AW-1:0] addr, input logic [1:0] op,
                           input logic [DW-1:0] data);
    bus.m_req_addr_i[m*AW +: AW] = addr;
    bus.m_req_op_i[m*2 +: 2]     = op;
    bus.m_req_data_i[m*DW +: DW] = data;
    bus.m_req_valid_i[m]         = 1'b1;
  endtask

  task automatic push_txn(input logic m, input logic [AW-1:0] addr, input logic [1:0] op,
                          input logic [DW-1:0] wdata, input logic [1:0] rresp,
                          input logic [DW-1:0] rdata);
    exp_req_q.push_back({m, addr, op, wdata});
    exp_rsp_q.push_back({m, rresp, rdata});
  endtask

  task automatic wait_sreq();
    int n;
    n = 0;
    while (!bus.s_req_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus.s_req_valid_o) check("sreq_wait_timeout", 64'd0, 64'd1);
  endtask

  // Plays the debug module: accept after req_dly cycles, respond rsp_dly cycles later.
  task automatic serve(input int req_dly, input int rsp_dly, input logic [1:0] rresp,
                       input logic [DW-1:0] rdata);
    int n;
    wait_sreq();
    repeat (req_dly) tick();
    bus.s_req_ready_i = 1'b1;
    tick();
    bus.s_req_ready_i = 1'b0;
    repeat (rsp_dly) tick();
    bus.s_resp_valid_i = 1'b1;
    bus.s_resp_resp_i  = rresp;
    bus.s_resp_data_i  = rdata;
    #1;
    n = 0;
    while (!bus.s_resp_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!bus.s_resp_ready_o) check("sresp_wait_timeout", 64'd0, 64'd1);
    tick();
    bus.s_resp_valid_i = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [41:0] er;
    logic [34:0] ep;
    if (!rst) begin
      if (bus.s_req_valid_o && bus.s_req_ready_i) begin
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", {22'd0, owner_o, bus.s_req_addr_o, bus.s_req_op_o,
                bus.s_req_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          er = exp_req_q.pop_front();
          check("req_fields", {22'd0, owner_o, bus.s_req_addr_o, bus.s_req_op_o,
                bus.s_req_data_o}, {22'd0, er});
        end
      end
      if (|(bus.m_resp_valid_o & bus.m_resp_ready_i)) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", {62'd0, bus.m_resp_valid_o}, 64'd0);
        end else begin
          ep = exp_rsp_q.pop_front();
          check("rsp_valid_bits", {62'd0, bus.m_resp_valid_o}, ep[34] ? 64'd2 : 64'd1);
          check("rsp_code_data", {30'd0, bus.m_resp_resp_o, bus.m_resp_data_o},
                {30'd0, ep[33:0]});
          check("rsp_owner", {63'd0, owner_o}, {63'd0, ep[34]});
        end
      end
      if (en != 2'b11) check("disabled_not_granted", {62'd0, bus.m_req_ready_o & ~en}, 64'd0);
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    en  = 2'b00;
    bus.m_req_valid_i  = '0;
    bus.m_req_addr_i   = '0;
    bus.m_req_op_i     = '0;
    bus.m_req_data_i   = '0;
    bus.m_resp_ready_i = 2'b11;
    bus.s_req_ready_i  = 1'b0;
    bus.s_resp_valid_i = 1'b0;
    bus.s_resp_resp_i  = '0;
    bus.s_resp_data_i  = '0;
    tick();
    tick();

    // reset values
    check("rst_state", {62'd0, state_o}, 64'd0);
    check("rst_rr", {63'd0, rr_ptr_o}, 64'd0);
    check("rst_owner", {63'd0, owner_o}, 64'd0);
    check("rst_stray", {63'd0, stray_o}, 64'd0);
    check("rst_valids", {59'd0, bus.s_req_valid_o, bus.m_req_ready_o, bus.m_resp_valid_o}, 64'd0);
    check("rst_sresp_ready", {63'd0, bus.s_resp_ready_o}, 64'd1);
    check("rst_req_fields", {22'd0, bus.s_req_addr_o, bus.s_req_op_o, bus.s_req_data_o}, 64'd0);
    rst = 1'b0;
    tick();

    // single read from master 0
    en = 2'b01;
    push_txn(1'b0, 7'h11, 2'd1, 32'd0, 2'd0, 32'hCAFE_F00D);
    drive_req(0, 7'h11, 2'd1, 32'd0);
    #1;
    check("t1_grant_comb", {62'd0, bus.m_req_ready_o}, 64'd1);
    check("t1_sreq_not_yet", {63'd0, bus.s_req_valid_o}, 64'd0);
    tick();
    bus.m_req_valid_i = 2'b00;
    check("t1_sreq_latency", {63'd0, bus.s_req_valid_o}, 64'd1);
    check("t1_ready_low_in_req", {62'd0, bus.m_req_ready_o}, 64'd0);
    serve(2, 3, 2'd0, 32'hCAFE_F00D);
    check("t1_idle_after", {62'd0, state_o}, 64'd0);
    check("t1_rr_flipped", {63'd0, rr_ptr_o}, 64'd1);

    // master 0 disabled, both requesting
    en = 2'b10;
    push_txn(1'b1, 7'h41, 2'd2, 32'h0000_0041, 2'd0, 32'h1111_0001);
    push_txn(1'b1, 7'h41, 2'd2, 32'h0000_0041, 2'd1, 32'h1111_0002);
    drive_req(0, 7'h40, 2'd1, 32'h0000_0040);
    drive_req(1, 7'h41, 2'd2, 32'h0000_0041);
    serve(0, 1, 2'd0, 32'h1111_0001);
    serve(1, 0, 2'd1, 32'h1111_0002);
    bus.m_req_valid_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis_m0_ready", {62'd0, bus.m_req_ready_o}, 64'd0);
      check("dis_stays_idle", {62'd0, state_o}, 64'd0);
    end
    bus.m_req_valid_i = 2'b00;

    // backpressure from master 0
    en = 2'b01;
    push_txn(1'b0, 7'h55, 2'd1, 32'h0000_0055, 2'd0, 32'hBEEF_0001);
    drive_req(0, 7'h55, 2'd1, 32'h0000_0055);
    tick();
    bus.m_req_valid_i = 2'b00;
    wait_sreq();
    bus.s_req_ready_i = 1'b1;
    tick();
    bus.s_req_ready_i  = 1'b0;
    bus.m_resp_ready_i = 2'b10;
    bus.s_resp_valid_i = 1'b1;
    bus.s_resp_resp_i  = 2'd0;
    bus.s_resp_data_i  = 32'hBEEF_0001;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_sresp_ready_low", {63'd0, bus.s_resp_ready_o}, 64'd0);
      check("bp_data_stable", {32'd0, bus.m_resp_data_o}, 64'hBEEF_0001);
      check("bp_valid_to_m0", {62'd0, bus.m_resp_valid_o}, 64'd1);
      tick();
    end
    bus.m_resp_ready_i = 2'b11;
    #1;
    check("bp_sresp_ready_high", {63'd0, bus.s_resp_ready_o}, 64'd1);
    tick();
    bus.s_resp_valid_i = 1'b0;
    check("bp_idle_after", {62'd0, state_o}, 64'd0);

    // fairness: both masters request continuously
    do_reset();
    en = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_txn(1'b0, 7'h20, 2'd1, 32'h0000_00A0, 2'd0, 32'h1000 + i);
      else            push_txn(1'b1, 7'h21, 2'd2, 32'h0000_00A1, 2'd0, 32'h1000 + i);
    end
    drive_req(0, 7'h20, 2'd1, 32'h0000_00A0);
    drive_req(1, 7'h21, 2'd2, 32'h0000_00A1);
    for (int i = 0; i < 6; i++) serve(i % 3, 1, 2'd0, 32'h1000 + i);
    bus.m_req_valid_i = 2'b00;
    tick();
    check("fair_drained_req", {32'd0, 32'(exp_req_q.size())}, 64'd0);

    // timeout with a late response afterwards
    begin
      int lat;
      en  = 2'b01;
      lat = 0;
      push_txn(1'b0, 7'h33, 2'd2, 32'h1234_5678, 2'b10, 32'd0);
      drive_req(0, 7'h33, 2'd2, 32'h1234_5678);
      tick();
      bus.m_req_valid_i = 2'b00;
      wait_sreq();
      bus.s_req_ready_i = 1'b1;
      tick();
      bus.s_req_ready_i = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bus.m_resp_valid_o != 2'b00) begin
          lat = k;
          break;
        end
      end
      check("to_latency", 64'(lat), 64'd8);
      check("to_err_state", {62'd0, state_o}, 64'd3);
      tick();
      check("to_stray_before_late", {63'd0, stray_o}, 64'd0);
      repeat (3) tick();
      bus.s_resp_valid_i = 1'b1;
      bus.s_resp_resp_i  = 2'd0;
      bus.s_resp_data_i  = 32'hDEAD_BEEF;
      #1;
      check("to_late_consumed", {63'd0, bus.s_resp_ready_o}, 64'd1);
      check("to_late_not_fwd", {62'd0, bus.m_resp_valid_o}, 64'd0);
      tick();
      bus.s_resp_valid_i = 1'b0;
      check("to_stray_set", {63'd0, stray_o}, 64'd1);
    end

    // reset while the request is pending at the debug module
    en = 2'b01;
    drive_req(0, 7'h66, 2'd1, 32'h0000_0066);
    tick();
    bus.m_req_valid_i = 2'b00;
    check("rr_in_req", {63'd0, bus.s_req_valid_o}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_async_drop", {63'd0, bus.s_req_valid_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rr_state_idle", {62'd0, state_o}, 64'd0);
    check("rr_ptr_zero", {63'd0, rr_ptr_o}, 64'd0);
    check("rr_stray_clear", {63'd0, stray_o}, 64'd0);
    push_txn(1'b0, 7'h77, 2'd1, 32'h0000_0077, 2'd0, 32'h7777_0000);
    drive_req(0, 7'h77, 2'd1, 32'h0000_0077);
    tick();
    bus.m_req_valid_i = 2'b00;
    serve(1, 2, 2'd0, 32'h7777_0000);
    tick();

    check("final_req_q_empty", 64'(exp_req_q.size()), 64'd0);
    check("final_rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
